// File: rtl/blend_rmw_writer_pkg.sv
// Shared pixel layout, colour limits and state encoding for the blend RMW writer.
package blend_rmw_writer_pkg;

  localparam int MAX_PIXEL_COLOR  = 31;
  localparam int MAX_PIXEL_LENGTH = 5;

  localparam int PX_R_LSB = 10;
  localparam int PX_G_LSB = 5;
  localparam int PX_B_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_BLEND   = 3'd3,
    ST_WR_REQ  = 3'd4
  } state_e;

  // Bit 15 is always packed as 0 and never read back.
  function automatic logic [15:0] px_pack(input logic [4:0] r, input logic [4:0] g,
                                          input logic [4:0] b);
    logic [15:0] px;
    px = '0;
    px[PX_R_LSB +: MAX_PIXEL_LENGTH] = r;
    px[PX_G_LSB +: MAX_PIXEL_LENGTH] = g;
    px[PX_B_LSB +: MAX_PIXEL_LENGTH] = b;
    return px;
  endfunction

  function automatic logic [4:0] px_chan(input logic [15:0] px, input int lsb);
    return px[lsb +: MAX_PIXEL_LENGTH];
  endfunction

endpackage

// File: rtl/blend_rmw_writer_color_blend.sv
// Subtractive RGB555 mixer: invert, sum, rescale so the largest sum fits, invert back.
module color_blend
  import blend_rmw_writer_pkg::*;
(
  input  logic [4:0] i_sdram_R,
  input  logic [4:0] i_sdram_G,
  input  logic [4:0] i_sdram_B,
  input  logic [4:0] i_draw_R,
  input  logic [4:0] i_draw_G,
  input  logic [4:0] i_draw_B,
  output logic [4:0] o_R,
  output logic [4:0] o_G,
  output logic [4:0] o_B
);

  logic [4:0] st  [3];
  logic [4:0] dr  [3];
  logic [5:0] sum [3];
  logic [4:0] res [3];
  logic [5:0] max_sum;
  logic [4:0] c;

  always_comb begin
    st[0] = i_sdram_R;
    st[1] = i_sdram_G;
    st[2] = i_sdram_B;
    dr[0] = i_draw_R;
    dr[1] = i_draw_G;
    dr[2] = i_draw_B;
    max_sum = '0;
    c = '0;
    for (int i = 0; i < 3; i++) begin
      sum[i] = 6'(5'(MAX_PIXEL_COLOR) - st[i]) + 6'(5'(MAX_PIXEL_COLOR) - dr[i]);
      if (sum[i] > max_sum) max_sum = sum[i];
    end
    for (int i = 0; i < 3; i++) begin
      // Rescale only when some channel saturated; the divide truncates.
      c = (max_sum > 6'(MAX_PIXEL_COLOR))
          ? 5'((11'(sum[i]) * 11'(MAX_PIXEL_COLOR)) / 11'(max_sum))
          : sum[i][4:0];
      res[i] = 5'(MAX_PIXEL_COLOR) - c;
    end
  end

  assign o_R = res[0];
  assign o_G = res[1];
  assign o_B = res[2];

endmodule

// File: rtl/blend_rmw_writer.sv
// Read-modify-write pixel engine between the brush generator and the SDRAM frame buffer.
//   state   | meaning
//   IDLE    | ready for a request; out-of-range requests are counted and dropped
//   RD_REQ  | read strobe held until the slave stops stalling
//   RD_WAIT | waiting for readdatavalid
//   BLEND   | one cycle: blended colour registered as writedata
//   WR_REQ  | write strobe held until the slave stops stalling
module blend_rmw_writer
  import blend_rmw_writer_pkg::*;
#(
  parameter int                H_RES     = 640,
  parameter int                V_RES     = 480,
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [9:0]        i_req_x,
  input  logic [8:0]        i_req_y,
  input  logic [4:0]        i_req_R,
  input  logic [4:0]        i_req_G,
  input  logic [4:0]        i_req_B,
  input  logic              i_req_blend,
  output logic [ADDR_W-1:0] o_sdram_addr,
  output logic              o_sdram_read,
  output logic              o_sdram_write,
  output logic [15:0]       o_sdram_writedata,
  input  logic              i_sdram_waitrequest,
  input  logic [15:0]       i_sdram_readdata,
  input  logic              i_sdram_readdatavalid,
  output logic              o_busy,
  output logic [15:0]       o_px_count,
  output logic [15:0]       o_drop_count
);

  state_e            state_q;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, brush_q, brush_d, rdata_q;
  logic [15:0]       px_q, drop_q;
  logic              in_range_d;
  logic [4:0]        bl_r, bl_g, bl_b;

  assign addr_d     = BASE_ADDR + ADDR_W'(i_req_y) * ADDR_W'(H_RES) + ADDR_W'(i_req_x);
  assign in_range_d = (32'(i_req_x) < H_RES) && (32'(i_req_y) < V_RES);
  assign brush_d    = px_pack(i_req_R, i_req_G, i_req_B);

  color_blend u_blend (
    .i_sdram_R (px_chan(rdata_q, PX_R_LSB)),
    .i_sdram_G (px_chan(rdata_q, PX_G_LSB)),
    .i_sdram_B (px_chan(rdata_q, PX_B_LSB)),
    .i_draw_R  (px_chan(brush_q, PX_R_LSB)),
    .i_draw_G  (px_chan(brush_q, PX_G_LSB)),
    .i_draw_B  (px_chan(brush_q, PX_B_LSB)),
    .o_R       (bl_r),
    .o_G       (bl_g),
    .o_B       (bl_b)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      brush_q <= '0;
      rdata_q <= '0;
      px_q    <= '0;
      drop_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req_valid) begin
            if (!in_range_d) begin
              drop_q <= drop_q + 16'd1;
            end else begin
              addr_q  <= addr_d;
              brush_q <= brush_d;
              if (i_req_blend) begin
                rd_q    <= 1'b1;
                state_q <= ST_RD_REQ;
              end else begin
                wdata_q <= brush_d;
                wr_q    <= 1'b1;
                state_q <= ST_WR_REQ;
              end
            end
          end
        end
        ST_RD_REQ: begin
          if (!i_sdram_waitrequest) begin
            rd_q    <= 1'b0;
            state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (i_sdram_readdatavalid) begin
            rdata_q <= i_sdram_readdata;
            state_q <= ST_BLEND;
          end
        end
        ST_BLEND: begin
          wdata_q <= px_pack(bl_r, bl_g, bl_b);
          wr_q    <= 1'b1;
          state_q <= ST_WR_REQ;
        end
        ST_WR_REQ: begin
          if (!i_sdram_waitrequest) begin
            wr_q    <= 1'b0;
            px_q    <= px_q + 16'd1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready       = (state_q == ST_IDLE);
  assign o_busy            = (state_q != ST_IDLE);
  assign o_sdram_read      = rd_q;
  assign o_sdram_write     = wr_q;
  assign o_sdram_addr      = addr_q;
  assign o_sdram_writedata = wdata_q;
  assign o_px_count        = px_q;
  assign o_drop_count      = drop_q;

endmodule
